// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the 7-segment scan controller: FSM state
// encodings, off-pattern helpers and the parameter legality check.
package seg7_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BLANK = 2'd1;
    localparam logic [1:0] ST_SHOW  = 2'd2;

    function automatic logic [7:0] seg_off(input bit active_low);
        return active_low ? 8'hFF : 8'h00;
    endfunction

    // Widest legal digit count is 8; callers slice down to NUM_DIGITS.
    function automatic logic [7:0] dig_off(input bit active_low);
        return active_low ? 8'hFF : 8'h00;
    endfunction

    function automatic bit params_legal(input int num_digits, input int scan_div,
                                        input int blank_cyc);
        return (num_digits >= 1) && (num_digits <= 8) && (scan_div >= 2) &&
               (blank_cyc >= 0) && (blank_cyc < scan_div);
    endfunction

endpackage

// File: rtl/drv7seg.sv
// Combinational hex-to-7-segment decoder; output is {dp,g,f,e,d,c,b,a}.
// Nibble 4'hC decodes to lowercase 'c' so it stays distinct from '0'.
module drv7seg #(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic [3:0] nib,
    input  logic       dp,
    output logic [7:0] seg
);

    logic [6:0] pat;

    always_comb begin
        pat = 7'h00;
        case (nib)
            4'h0: pat = 7'h3F;
            4'h1: pat = 7'h06;
            4'h2: pat = 7'h5B;
            4'h3: pat = 7'h4F;
            4'h4: pat = 7'h66;
            4'h5: pat = 7'h6D;
            4'h6: pat = 7'h7D;
            4'h7: pat = 7'h07;
            4'h8: pat = 7'h7F;
            4'h9: pat = 7'h6F;
            4'hA: pat = 7'h77;
            4'hB: pat = 7'h7C;
            4'hC: pat = 7'h58;
            4'hD: pat = 7'h5E;
            4'hE: pat = 7'h79;
            4'hF: pat = 7'h71;
            default: pat = 7'h00;
        endcase
    end

    assign seg = ACTIVE_LOW ? ~{dp, pat} : {dp, pat};

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed N-digit 7-seg scan controller with per-slot blanking gap
// and once-per-frame value snapshot. Define SEG7_LZB_EN for leading-zero blanking.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 1024,
    parameter int BLANK_CYC      = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit DIG_ACTIVE_LOW = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   dig,
    output logic                    frame_done
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    // With no blanking gap a new slot starts directly in SHOW.
    localparam logic [1:0] ST_SLOT = (BLANK_CYC == 0) ? ST_SHOW : ST_BLANK;
    localparam logic [7:0] SEG_OFF  = seg_off(SEG_ACTIVE_LOW);
    localparam logic [7:0] DIG_OFF8 = dig_off(DIG_ACTIVE_LOW);
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = DIG_OFF8[NUM_DIGITS-1:0];

    generate
        if (!params_legal(NUM_DIGITS, SCAN_DIV, BLANK_CYC)) begin : g_bad_params
            $error("seg7_scan_ctrl: illegal NUM_DIGITS/SCAN_DIV/BLANK_CYC");
        end
    endgenerate

    logic [1:0]                  state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [NUM_DIGITS-1:0][3:0]  snap_val_q, snap_val_d;
    logic [NUM_DIGITS-1:0]       snap_dp_q, snap_dp_d;
    logic [7:0]                  seg_q, seg_d;
    logic [NUM_DIGITS-1:0]       dig_q, dig_d;
    logic                        frame_done_q, frame_done_d;

    logic [7:0]            dec_seg;
    logic [NUM_DIGITS-1:0] lzb_dark;
    logic [NUM_DIGITS-1:0] dig_on;
    logic                  show;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        snap_val_d   = snap_val_q;
        snap_dp_d    = snap_dp_q;
        frame_done_d = 1'b0;
        if (!en) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_BLANK: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == BLANK_LAST) state_d = ST_SHOW;
                end
                ST_SHOW: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_SLOT;
                        if (idx_q == IDX_LAST) begin
                            idx_d        = '0;
                            snap_val_d   = value;
                            snap_dp_d    = dp_in;
                            frame_done_d = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    snap_val_d = value;
                    snap_dp_d  = dp_in;
                    cnt_d      = '0;
                    idx_d      = '0;
                    state_d    = ST_SLOT;
                end
            endcase
        end
    end

`ifdef SEG7_LZB_EN
    logic zero_run;
    // A digit is dark when it and every digit left of it is a plain zero.
    always_comb begin
        lzb_dark = '0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_run    = zero_run && (snap_val_q[i] == 4'h0) && !snap_dp_q[i];
            lzb_dark[i] = zero_run;
        end
    end
`else
    assign lzb_dark = '0;
`endif

    drv7seg #(
        .ACTIVE_LOW(SEG_ACTIVE_LOW)
    ) u_dec (
        .nib (snap_val_q[idx_q]),
        .dp  (snap_dp_q[idx_q]),
        .seg (dec_seg)
    );

    always_comb begin
        show   = en && (state_q == ST_SHOW) && !lzb_dark[idx_q];
        dig_on = '0;
        if (show) dig_on[idx_q] = 1'b1;
        dig_d = DIG_ACTIVE_LOW ? ~dig_on : dig_on;
        seg_d = show ? dec_seg : SEG_OFF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            snap_val_q   <= '0;
            snap_dp_q    <= '0;
            seg_q        <= SEG_OFF;
            dig_q        <= DIG_OFF;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            snap_val_q   <= snap_val_d;
            snap_dp_q    <= snap_dp_d;
            seg_q        <= seg_d;
            dig_q        <= dig_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign dig        = dig_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl (4 digits, 8-cycle slots, 2 blank cycles);
// a second instance with inverted polarities shares the same stimulus.
module tb_seg7_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [7:0]  seg, seg_n;
    logic [3:0]  dig, dig_n;
    logic        frame_done, frame_done_n;

    int total = 0;
    int bad   = 0;
    bit lzb;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(
        .NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYC(2),
        .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .value(value), .dp_in(dp_in),
        .seg(seg), .dig(dig), .frame_done(frame_done)
    );

    seg7_scan_ctrl #(
        .NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYC(2),
        .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
    ) dut_n (
        .clk(clk), .rst_n(rst_n), .en(en), .value(value), .dp_in(dp_in),
        .seg(seg_n), .dig(dig_n), .frame_done(frame_done_n)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Return to IDLE, load new inputs, and take the IDLE->BLANK edge.
    task automatic restart(input logic [15:0] v, input logic [3:0] dp);
        en = 1'b0;
        tick();
        value = v;
        dp_in = dp;
        en    = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; value = 16'h1234; dp_in = 4'b0000;
        #12;
        total++;
        if ({dig, seg, frame_done} !== {4'b0000, 8'h00, 1'b0}) begin
            bad++; $display("FAIL reset_init: dig=%b seg=%h fd=%b want 0000/00/0", dig, seg, frame_done);
        end
        total++;
        if ({dig_n, seg_n, frame_done_n} !== {4'b1111, 8'hFF, 1'b0}) begin
            bad++; $display("FAIL reset_init_n: dig=%b seg=%h fd=%b want 1111/ff/0", dig_n, seg_n, frame_done_n);
        end
        rst_n = 1'b1;
        tick();
        en = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        total++;
        if ({dig, seg} !== {4'b0001, 8'h66}) begin
            bad++; $display("FAIL reset_prescan: dig=%b seg=%h want 0001/66", dig, seg);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({dig, seg, frame_done} !== {4'b0000, 8'h00, 1'b0}) begin
            bad++; $display("FAIL reset_async: dig=%b seg=%h fd=%b want 0000/00/0", dig, seg, frame_done);
        end
        en = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({dig, seg, frame_done} !== {4'b0000, 8'h00, 1'b0}) begin
                bad++; $display("FAIL reset_dark c%0d: dig=%b seg=%h fd=%b want 0000/00/0", i, dig, seg, frame_done);
            end
        end
    endtask

    task automatic test_scan();
        logic [7:0] tbl [4] = '{8'h66, 8'h4F, 8'h5B, 8'h06};
        logic [3:0] e_dig;
        logic [7:0] e_seg;
        logic       e_fd;
        restart(16'h1234, 4'b0000);
        total++;
        if ({dig, seg} !== {4'b0000, 8'h00}) begin
            bad++; $display("FAIL scan_start: dig=%b seg=%h want 0000/00", dig, seg);
        end
        for (int f = 0; f < 2; f++)
            for (int k = 0; k < 4; k++)
                for (int c = 1; c <= 8; c++) begin
                    tick();
                    e_dig = (c <= 2) ? 4'b0000 : 4'b0001 << k;
                    e_seg = (c <= 2) ? 8'h00 : tbl[k];
                    e_fd  = (k == 3) && (c == 8);
                    total++;
                    if ({dig, seg, frame_done} !== {e_dig, e_seg, e_fd}) begin
                        bad++;
                        $display("FAIL scan f%0d k%0d c%0d: dig=%b seg=%h fd=%b want %b/%h/%b",
                                 f, k, c, dig, seg, frame_done, e_dig, e_seg, e_fd);
                    end
                end
    endtask

    task automatic test_snapshot();
        logic [7:0] t0 [4] = '{8'h66, 8'h4F, 8'h5B, 8'h06};
        logic [7:0] t1 [4] = '{8'h5E, 8'h58, 8'h7C, 8'h77};
        logic [3:0] e_dig;
        logic [7:0] e_seg;
        restart(16'h1234, 4'b0000);
        for (int f = 0; f < 2; f++)
            for (int k = 0; k < 4; k++)
                for (int c = 1; c <= 8; c++) begin
                    if (f == 0 && k == 2 && c == 4) value = 16'hABCD;
                    tick();
                    e_dig = (c <= 2) ? 4'b0000 : 4'b0001 << k;
                    e_seg = (c <= 2) ? 8'h00 : ((f == 0) ? t0[k] : t1[k]);
                    total++;
                    if ({dig, seg} !== {e_dig, e_seg}) begin
                        bad++;
                        $display("FAIL snapshot f%0d k%0d c%0d: dig=%b seg=%h want %b/%h",
                                 f, k, c, dig, seg, e_dig, e_seg);
                    end
                end
    endtask

    task automatic test_en_drop();
        restart(16'h1234, 4'b0000);
        for (int i = 0; i < 20; i++) tick();
        total++;
        if ({dig, seg} !== {4'b0100, 8'h5B}) begin
            bad++; $display("FAIL endrop_pre: dig=%b seg=%h want 0100/5b", dig, seg);
        end
        en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            total++;
            if ({dig, seg, frame_done} !== {4'b0000, 8'h00, 1'b0}) begin
                bad++; $display("FAIL endrop_dark c%0d: dig=%b seg=%h fd=%b want 0000/00/0", i, dig, seg, frame_done);
            end
        end
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({dig, seg} !== {4'b0000, 8'h00}) begin
                bad++; $display("FAIL enrise_dark c%0d: dig=%b seg=%h want 0000/00", i, dig, seg);
            end
        end
        tick();
        total++;
        if ({dig, seg} !== {4'b0001, 8'h66}) begin
            bad++; $display("FAIL enrise_digit0: dig=%b seg=%h want 0001/66", dig, seg);
        end
    endtask

    task automatic test_dp_polarity();
        logic [3:0] e_dig;
        logic [7:0] e_seg;
        logic       dark;
        restart(16'h0000, 4'b0010);
        for (int k = 0; k < 4; k++)
            for (int c = 1; c <= 8; c++) begin
                tick();
                dark  = (c <= 2) || (lzb && k >= 2);
                e_dig = dark ? 4'b0000 : 4'b0001 << k;
                e_seg = dark ? 8'h00 : ((k == 1) ? 8'hBF : 8'h3F);
                total++;
                if ({dig, seg} !== {e_dig, e_seg}) begin
                    bad++; $display("FAIL dp k%0d c%0d: dig=%b seg=%h want %b/%h", k, c, dig, seg, e_dig, e_seg);
                end
                total++;
                if ({dig_n, seg_n} !== {~e_dig, ~e_seg}) begin
                    bad++; $display("FAIL dp_inv k%0d c%0d: dig=%b seg=%h want %b/%h", k, c, dig_n, seg_n, ~e_dig, ~e_seg);
                end
            end
    endtask

    task automatic test_lzb();
        logic [7:0] tbl [4] = '{8'h3F, 8'h6D, 8'h3F, 8'h3F};
        logic [3:0] e_dig;
        logic [7:0] e_seg;
        logic       dark;
        logic       e_fd;
        restart(16'h0050, 4'b0000);
        for (int k = 0; k < 4; k++)
            for (int c = 1; c <= 8; c++) begin
                tick();
                dark  = (c <= 2) || (lzb && k >= 2);
                e_dig = dark ? 4'b0000 : 4'b0001 << k;
                e_seg = dark ? 8'h00 : tbl[k];
                e_fd  = (k == 3) && (c == 8);
                total++;
                if ({dig, seg, frame_done} !== {e_dig, e_seg, e_fd}) begin
                    bad++;
                    $display("FAIL lzb k%0d c%0d: dig=%b seg=%h fd=%b want %b/%h/%b",
                             k, c, dig, seg, frame_done, e_dig, e_seg, e_fd);
                end
            end
    endtask

    initial begin
`ifdef SEG7_LZB_EN
        lzb = 1'b1;
`else
        lzb = 1'b0;
`endif
        test_reset();
        test_scan();
        test_snapshot();
        test_en_drop();
        test_dp_polarity();
        test_lzb();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
